// File: rtl/sprite_sched_pkg.sv
// Shared constants and the per-object configuration record for the sprite scheduler.
package sprite_sched_pkg;

    localparam int unsigned NUM_OBJ  = 4;
    localparam int unsigned SPR_W    = 16;
    localparam int unsigned SPR_H    = 16;
    localparam int unsigned NUM_IMG  = 16;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned IMG_W    = $clog2(NUM_IMG);
    localparam int unsigned ROM_AW   = $clog2(NUM_IMG * SPR_W * SPR_H);

    typedef struct packed {
        logic             en;
        logic [9:0]       x;
        logic [9:0]       y;
        logic [IMG_W-1:0] img;
    } obj_cfg_t;

endpackage

// File: rtl/sprite_hit_test.sv
// Coverage test for one object against the current pixel, plus its ROM address.
module sprite_hit_test
    import sprite_sched_pkg::*;
(
    input  obj_cfg_t          obj,
    input  logic [9:0]        draw_x,
    input  logic [9:0]        draw_y,
    output logic              hit,
    output logic [ROM_AW-1:0] addr
);

    localparam int unsigned CB = $clog2(SPR_W);
    localparam int unsigned RB = $clog2(SPR_H);

    logic [10:0]   px, py, x0, y0;
    logic [CB-1:0] col_off;
    logic [RB-1:0] row_off;

    // 11-bit compare keeps objects near column 1023 from wrapping onto column 0
    assign px = {1'b0, draw_x};
    assign py = {1'b0, draw_y};
    assign x0 = {1'b0, obj.x};
    assign y0 = {1'b0, obj.y};

    assign hit = obj.en && (px >= x0) && (px < x0 + 11'(SPR_W))
                        && (py >= y0) && (py < y0 + 11'(SPR_H));

    // Power-of-two sprite size: low bits of the difference are the local offset
    assign col_off = draw_x[CB-1:0] - obj.x[CB-1:0];
    assign row_off = draw_y[RB-1:0] - obj.y[RB-1:0];
    assign addr    = {obj.img, row_off, col_off};

endmodule

// File: rtl/sprite_layer_scheduler.sv
// Per-pixel sprite arbitration over a shared synchronous ROM, with shadowed
// object tables committed at the start of vertical blank.
module sprite_layer_scheduler #(
    parameter int unsigned NUM_OBJ  = 4,
    parameter int unsigned SPR_W    = 16,
    parameter int unsigned SPR_H    = 16,
    parameter int unsigned NUM_IMG  = 16,
    parameter int unsigned V_ACTIVE = 480
) (
    input  logic                                  vga_clk,
    input  logic                                  reset_n,
    input  logic [9:0]                            DrawX,
    input  logic [9:0]                            DrawY,
    input  logic                                  blank,
    input  logic                                  cfg_valid,
    output logic                                  cfg_ready,
    input  logic [$clog2(NUM_OBJ)-1:0]            cfg_obj,
    input  logic                                  cfg_en,
    input  logic [9:0]                            cfg_x,
    input  logic [9:0]                            cfg_y,
    input  logic [$clog2(NUM_IMG)-1:0]            cfg_img,
    output logic [$clog2(NUM_IMG*SPR_W*SPR_H)-1:0] rom_addr,
    input  logic [3:0]                            rom_q,
    output logic [3:0]                            pix_index,
    output logic                                  pix_hit,
    output logic [$clog2(NUM_OBJ)-1:0]            pix_obj,
    output logic                                  blank_out,
    output logic [7:0]                            frame_cnt
);

    import sprite_sched_pkg::*;

    localparam int unsigned OW = $clog2(NUM_OBJ);

    obj_cfg_t          shadow [NUM_OBJ];
    obj_cfg_t          active [NUM_OBJ];
    logic              ready_en;
    logic              commit;
    logic [NUM_OBJ-1:0] obj_hit;
    logic [ROM_AW-1:0] obj_addr [NUM_OBJ];

    logic              win_hit;
    logic [OW-1:0]     win_obj;
    logic [ROM_AW-1:0] win_addr;

    logic              s1_hit, s1_blank;
    logic [OW-1:0]     s1_obj;
    logic              s2_hit, s2_blank;
    logic [OW-1:0]     s2_obj;

    assign commit    = (DrawX == 10'd0) && (DrawY == 10'(V_ACTIVE));
    assign cfg_ready = ready_en && !commit;

    for (genvar i = 0; i < NUM_OBJ; i++) begin : g_obj
        sprite_hit_test u_hit (
            .obj    (active[i]),
            .draw_x (DrawX),
            .draw_y (DrawY),
            .hit    (obj_hit[i]),
            .addr   (obj_addr[i])
        );
    end

    // Scan from the top index down so the lowest covering index is the last write
    always_comb begin
        win_hit  = 1'b0;
        win_obj  = '0;
        win_addr = '0;
        for (int unsigned i = NUM_OBJ; i > 0; i--) begin
            if (obj_hit[i-1]) begin
                win_hit  = 1'b1;
                win_obj  = OW'(i - 1);
                win_addr = obj_addr[i-1];
            end
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_en  <= 1'b0;
            frame_cnt <= '0;
            for (int unsigned i = 0; i < NUM_OBJ; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            ready_en <= 1'b1;
            if (cfg_valid && cfg_ready)
                shadow[cfg_obj] <= '{en: cfg_en, x: cfg_x, y: cfg_y, img: cfg_img};
            if (commit) begin
                active    <= shadow;
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr  <= '0;
            s1_hit    <= 1'b0;
            s1_obj    <= '0;
            s1_blank  <= 1'b0;
            s2_hit    <= 1'b0;
            s2_obj    <= '0;
            s2_blank  <= 1'b0;
            pix_index <= '0;
            pix_hit   <= 1'b0;
            pix_obj   <= '0;
            blank_out <= 1'b0;
        end else begin
            if (win_hit)
                rom_addr <= win_addr;
            s1_hit    <= win_hit;
            s1_obj    <= win_obj;
            s1_blank  <= blank;
            s2_hit    <= s1_hit;
            s2_obj    <= s1_obj;
            s2_blank  <= s1_blank;
            pix_index <= (s2_hit && s2_blank) ? rom_q : '0;
            pix_hit   <= s2_hit && s2_blank && (rom_q != '0);
            pix_obj   <= (s2_hit && s2_blank && (rom_q != '0)) ? s2_obj : '0;
            blank_out <= s2_blank;
        end
    end

endmodule

// File: tb/tb_sprite_layer_scheduler.sv
// Bench for sprite_layer_scheduler: directed vector tables plus randomized
// traffic against a behavioural object-list model.
module tb_sprite_layer_scheduler;

    logic        vga_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  DrawX = '0, DrawY = '0;
    logic        blank = 1'b0, cfg_valid = 1'b0, cfg_en = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_obj = '0;
    logic [9:0]  cfg_x = '0, cfg_y = '0;
    logic [3:0]  cfg_img = '0;
    logic [11:0] rom_addr;
    logic [3:0]  rom_q = '0;
    logic [3:0]  pix_index;
    logic        pix_hit;
    logic [1:0]  pix_obj;
    logic        blank_out;
    logic [7:0]  frame_cnt;

    sprite_layer_scheduler #(
        .NUM_OBJ(4), .SPR_W(16), .SPR_H(16), .NUM_IMG(16), .V_ACTIVE(480)
    ) dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
        .blank(blank), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_obj(cfg_obj), .cfg_en(cfg_en), .cfg_x(cfg_x), .cfg_y(cfg_y),
        .cfg_img(cfg_img), .rom_addr(rom_addr), .rom_q(rom_q),
        .pix_index(pix_index), .pix_hit(pix_hit), .pix_obj(pix_obj),
        .blank_out(blank_out), .frame_cnt(frame_cnt)
    );

    always #5 vga_clk = ~vga_clk;

    logic [3:0] rom_mem [4096];
    always @(posedge vga_clk) rom_q <= rom_mem[rom_addr];

    typedef struct { bit en; int x; int y; int img; } mobj_t;
    typedef struct { int idx; bit hit; int obj; bit blk; } out_t;
    typedef struct { int x; int y; bit b; int addr; int idx; bit hit; int obj; } vec_t;

    mobj_t m_shadow [4];
    mobj_t m_active [4];
    int    m_frame, m_addr;
    out_t  expq [$];
    vec_t  vt [$];
    int    checks = 0, errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void eval(input int x, input int y, output bit h, output int o, output int a);
        h = 0; o = 0; a = 0;
        for (int i = 0; i < 4; i++) begin
            if (!h && m_active[i].en &&
                x >= m_active[i].x && x < m_active[i].x + 16 &&
                y >= m_active[i].y && y < m_active[i].y + 16) begin
                h = 1;
                o = i;
                a = m_active[i].img * 256 + (y - m_active[i].y) * 16 + (x - m_active[i].x);
            end
        end
    endfunction

    // One pixel per call; entered and left at a falling clock edge.
    task automatic step(input int x, input int y, input bit b,
                        input bit cv = 0, input int co = 0, input bit ce = 0,
                        input int cx = 0, input int cy = 0, input int ci = 0);
        bit   h, rdy;
        int   o, a;
        out_t r;
        DrawX = x[9:0]; DrawY = y[9:0]; blank = b;
        cfg_valid = cv; cfg_obj = co[1:0]; cfg_en = ce;
        cfg_x = cx[9:0]; cfg_y = cy[9:0]; cfg_img = ci[3:0];
        #1;
        rdy = !(x == 0 && y == 480);
        check("cfg_ready", {31'd0, cfg_ready}, {31'd0, rdy});
        eval(x, y, h, o, a);
        if (h) m_addr = a;
        r.blk = b;
        r.idx = (h && b) ? int'(rom_mem[a]) : 0;
        r.hit = h && b && rom_mem[a] != 4'd0;
        r.obj = r.hit ? o : 0;
        expq.push_back(r);
        if (cv && rdy) m_shadow[co] = '{ce, cx, cy, ci};
        if (!rdy) begin
            m_active = m_shadow;
            m_frame  = (m_frame + 1) % 256;
        end
        @(posedge vga_clk); #1;
        check("rom_addr", rom_addr, m_addr);
        check("frame_cnt", frame_cnt, m_frame);
        r = expq.pop_front();
        check("pix_index", pix_index, r.idx);
        check("pix_hit", pix_hit, r.hit);
        check("pix_obj", pix_obj, r.obj);
        check("blank_out", blank_out, r.blk);
        @(negedge vga_clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rom_addr"}, rom_addr, 0);
        check({tag, "_pix_index"}, pix_index, 0);
        check({tag, "_pix_hit"}, pix_hit, 0);
        check({tag, "_pix_obj"}, pix_obj, 0);
        check({tag, "_blank_out"}, blank_out, 0);
        check({tag, "_frame_cnt"}, frame_cnt, 0);
        check({tag, "_cfg_ready"}, cfg_ready, 0);
    endtask

    task automatic do_reset();
        out_t z;
        @(negedge vga_clk);
        #2;
        reset_n = 1'b0;
        cfg_valid = 1'b0; blank = 1'b0; DrawX = 10'd990; DrawY = 10'd1000;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge vga_clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m_shadow[i] = '{0, 0, 0, 0};
            m_active[i] = '{0, 0, 0, 0};
        end
        m_frame = 0; m_addr = 0;
        expq.delete();
        z = '{0, 0, 0, 0};
        expq.push_back(z);
        expq.push_back(z);
        @(negedge vga_clk);
    endtask

    task automatic add(input int x, input int y, input bit b, input int addr,
                       input int idx, input bit hit, input int obj);
        vec_t v;
        v = '{x, y, b, addr, idx, hit, obj};
        vt.push_back(v);
    endtask

    task automatic run_vecs(input string tag);
        for (int i = 0; i < vt.size(); i++) begin
            step(vt[i].x, vt[i].y, vt[i].b);
            check({tag, "_addr"}, rom_addr, vt[i].addr);
            step(990, 1000, 0);
            step(990, 1000, 0);
            check({tag, "_index"}, pix_index, vt[i].idx);
            check({tag, "_hit"}, pix_hit, vt[i].hit);
            check({tag, "_obj"}, pix_obj, vt[i].obj);
        end
        vt.delete();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom_mem[i] = 4'($urandom_range(0, 15));
        rom_mem[595] = 4'd7;  rom_mem[512] = 4'd3;  rom_mem[767] = 4'd0;
        rom_mem[426] = 4'd0;  rom_mem[930] = 4'd9;  rom_mem[273] = 4'd5;
        rom_mem[860] = 4'd4;  rom_mem[1109] = 4'd6; rom_mem[1575] = 4'd8;

        do_reset();

        // Nothing configured: sampled visible pixels stay background
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 639), $urandom_range(0, 479), 1);
        step(0, 480, 0);
        check("first_commit_frame", frame_cnt, 1);

        // Single object
        step(10, 490, 0, 1, 0, 1, 100, 50, 2);
        step(0, 480, 0);
        add(103, 55, 1, 595, 7, 1, 0);
        add(100, 50, 1, 512, 3, 1, 0);
        add(115, 65, 1, 767, 0, 0, 0);
        add(116, 55, 1, 767, 0, 0, 0);
        add(99, 55, 1, 767, 0, 0, 0);
        add(103, 55, 0, 595, 0, 0, 0);
        add(103, 66, 1, 595, 0, 0, 0);
        run_vecs("single");

        // Overlap: object 0 wins, transparent winner shows background
        step(10, 490, 0, 1, 0, 1, 200, 200, 1);
        step(11, 490, 0, 1, 2, 1, 208, 200, 3);
        step(12, 490, 0, 1, 1, 1, 100, 300, 4);
        step(0, 480, 0);
        add(210, 210, 1, 426, 0, 0, 0);
        add(201, 201, 1, 273, 5, 1, 0);
        add(220, 205, 1, 860, 4, 1, 2);
        run_vecs("overlap");

        // Mid-frame write stays in the shadow until the commit
        step(50, 100, 1, 1, 1, 1, 300, 300, 4);
        add(105, 305, 1, 1109, 6, 1, 1);
        add(305, 305, 1, 1109, 0, 0, 0);
        run_vecs("preframe");
        step(0, 480, 0, 1, 3, 1, 0, 0, 5);
        add(105, 305, 1, 1109, 0, 0, 0);
        add(305, 305, 1, 1109, 6, 1, 1);
        add(3, 3, 1, 1109, 0, 0, 0);
        run_vecs("postframe");

        // Right-edge clipping and no wrap near column 1023
        step(10, 490, 0, 1, 3, 1, 1020, 10, 5);
        step(11, 490, 0, 1, 1, 1, 632, 10, 6);
        step(0, 480, 0);
        for (int x = 0; x < 4; x++) step(x, 12, 1);
        for (int x = 628; x < 648; x++) step(x, 12, x < 640);
        for (int x = 1018; x < 1024; x++) step(x, 12, 0);
        add(639, 12, 1, 1575, 8, 1, 1);
        add(640, 12, 0, 1576, 0, 0, 0);
        add(2, 12, 1, 1576, 0, 0, 0);
        add(631, 12, 1, 1576, 0, 0, 0);
        run_vecs("edge");

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if (i % 97 == 96) begin
                step(0, 480, 0, $urandom_range(0, 1), $urandom_range(0, 3), 1, 5, 5, 1);
            end else if ($urandom_range(0, 7) == 0) begin
                step($urandom_range(0, 140), $urandom_range(0, 140), $urandom_range(0, 3) != 0,
                     1, $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                     ($urandom_range(0, 9) == 0) ? $urandom_range(1010, 1023) : $urandom_range(0, 120),
                     $urandom_range(0, 120), $urandom_range(0, 15));
            end else begin
                step(($urandom_range(0, 19) == 0) ? $urandom_range(1000, 1023) : $urandom_range(0, 140),
                     $urandom_range(0, 140), $urandom_range(0, 3) != 0);
            end
        end

        // frame_cnt wraps through 255 -> 0
        for (int i = 0; i < 260; i++) step(0, 480, 0);

        // Reset mid-line with objects live
        step(10, 490, 0, 1, 0, 1, 100, 50, 2);
        step(0, 480, 0);
        step(103, 55, 1);
        step(104, 55, 1);
        do_reset();
        for (int i = 0; i < 5; i++) step(103, 55, 1);
        step(0, 480, 0);
        for (int i = 0; i < 3; i++) step(103, 55, 1);
        check("post_reset_hit", pix_hit, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
